// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt source controller: bus width and
// register window layout (offsets from the base address).
package irq_ctrl_pkg;

    localparam int unsigned BUS_W    = 8;
    localparam int unsigned NUM_REGS = 5;

    localparam logic [BUS_W-1:0] OFF_STATUS  = 8'd0;
    localparam logic [BUS_W-1:0] OFF_PENDING = 8'd1;
    localparam logic [BUS_W-1:0] OFF_MASK    = 8'd2;
    localparam logic [BUS_W-1:0] OFF_EDGE    = 8'd3;
    localparam logic [BUS_W-1:0] OFF_BOTH    = 8'd4;

endpackage

// File: rtl/irq_controller_if.sv
// Processor-side signals of the interrupt controller: bus address/write
// strobe plus the per-line interrupt raise/acknowledge pair.
//   addr      bus address
//   we        bus write enable
//   irq_ack   per-line acknowledge pulse from the processor
//   irq_raise per-line interrupt request to the processor
interface irq_controller_if #(
    parameter int unsigned N_CH = 4
);
    import irq_ctrl_pkg::*;

    logic [BUS_W-1:0] addr;
    logic             we;
    logic [N_CH-1:0]  irq_ack;
    logic [N_CH-1:0]  irq_raise;

    modport master (output addr, output we, output irq_ack, input irq_raise);
    modport slave  (input addr, input we, input irq_ack, output irq_raise);

endinterface

// File: rtl/debounce_channel.sv
// One interrupt input: multi-flop synchroniser followed by a debounce
// counter. The input must disagree with the accepted level for
// 2^DEB_BITS consecutive cycles before the accepted level follows it.
//   clk, rst_n  clock, async active-low reset
//   raw         asynchronous source
//   stable      accepted (debounced) level
//   rise_evt_c  stable is going 0->1 on this edge
//   fall_evt_c  stable is going 1->0 on this edge
module debounce_channel #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_BITS    = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise_evt_c,
    output logic fall_evt_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_BITS-1:0]    cnt_q;
    logic                   sync;
    logic                   accept;

    assign sync   = sync_q[SYNC_STAGES-1];
    // Counter saturated while still disagreeing: the new level is taken now.
    assign accept = (sync != stable) && (cnt_q == '1);

    assign rise_evt_c = accept &  sync;
    assign fall_evt_c = accept & ~sync;

    // Synchroniser shift register and debounce counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync == stable) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + DEB_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt source controller on the 8-bit memory-mapped bus. Each raw
// source is synchronised and debounced; selected edges latch a pending
// bit which, when unmasked, raises the matching processor interrupt.
//   clk, rst_n  clock, async active-low reset
//   raw_in      asynchronous interrupt sources
//   bus_data    shared bus data, driven only the cycle after a read hit
//   bus         address, write enable, irq_ack in; irq_raise out
//   level       debounced input levels
// Register window at BASE_ADDR: +0 STATUS (RO), +1 PENDING (W1C),
// +2 MASK, +3 EDGE (1=falling), +4 BOTH (1=both edges).
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned      N_CH        = 4,
    parameter logic [BUS_W-1:0] BASE_ADDR   = 8'hD0,
    parameter int unsigned      DEB_BITS    = 20,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      raw_in,
    inout  wire  [BUS_W-1:0]     bus_data,
    irq_controller_if.slave      bus,
    output logic [N_CH-1:0]      level
);

    logic [BUS_W-1:0] off;
    logic             hit;
    logic             wr_en;
    logic             rd_en;
    logic [N_CH-1:0]  wdata;
    logic [N_CH-1:0]  rise_evt;
    logic [N_CH-1:0]  fall_evt;
    logic [N_CH-1:0]  evt_set;
    logic [N_CH-1:0]  pend_clr;
    logic [N_CH-1:0]  pend_q;
    logic [N_CH-1:0]  mask_q;
    logic [N_CH-1:0]  edge_q;
    logic [N_CH-1:0]  both_q;
    logic [BUS_W-1:0] rdata_d;
    logic [BUS_W-1:0] rdata_q;
    logic             oe_q;
    logic             unused_data;

    // Offset arithmetic wraps, so the window test is a single compare.
    assign off   = bus.addr - BASE_ADDR;
    assign hit   = off < BUS_W'(NUM_REGS);
    assign wr_en = hit &  bus.we;
    assign rd_en = hit & ~bus.we;
    assign wdata = bus_data[N_CH-1:0];
    // Upper data bits have no register behind them.
    assign unused_data = ^bus_data;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_BITS    (DEB_BITS)
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (raw_in[g]),
            .stable     (level[g]),
            .rise_evt_c (rise_evt[g]),
            .fall_evt_c (fall_evt[g])
        );
    end

    // Edge qualification and pending-clear sources.
    assign evt_set  = (rise_evt & (both_q | ~edge_q)) | (fall_evt & (both_q | edge_q));
    assign pend_clr = bus.irq_ack | ((wr_en && (off == OFF_PENDING)) ? wdata : '0);

    // Read mux; bits above N_CH read as zero.
    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_STATUS:  rdata_d = BUS_W'(level);
            OFF_PENDING: rdata_d = BUS_W'(pend_q);
            OFF_MASK:    rdata_d = BUS_W'(mask_q);
            OFF_EDGE:    rdata_d = BUS_W'(edge_q);
            OFF_BOTH:    rdata_d = BUS_W'(both_q);
            default:     rdata_d = '0;
        endcase
    end

    // Control registers, pending latch (set beats clear), irq and read pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            mask_q        <= '0;
            edge_q        <= '0;
            both_q        <= '0;
            bus.irq_raise <= '0;
            rdata_q       <= '0;
            oe_q          <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | evt_set;
            if (wr_en) begin
                case (off)
                    OFF_MASK: mask_q <= wdata;
                    OFF_EDGE: edge_q <= wdata;
                    OFF_BOTH: both_q <= wdata;
                    default:  ;
                endcase
            end
            bus.irq_raise <= pend_q & mask_q;
            rdata_q       <= rd_en ? rdata_d : '0;
            oe_q          <= rd_en;
        end
    end

    assign bus_data = oe_q ? rdata_q : {BUS_W{1'bz}};

endmodule

// File: tb/tb_irq_controller.sv
// Randomised plus directed bench for irq_controller. A reference model
// tracks sampled input history and register state; it queues one
// expectation per clock edge and a negedge monitor compares them.
module tb_irq_controller;
    import irq_ctrl_pkg::*;

    localparam int unsigned NC  = 4;
    localparam int unsigned DB  = 4;
    localparam int unsigned SS  = 2;
    localparam int          DEB = 16;
    localparam int          LAT = 18;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [NC-1:0] raw_in   = '0;
    logic [7:0]    drv_data = 8'h00;
    logic          drv_oe   = 1'b0;
    logic [NC-1:0] level;
    tri1  [7:0]    bus_data;

    assign bus_data = drv_oe ? drv_data : 8'hzz;

    irq_controller_if #(.N_CH(NC)) bus ();

    irq_controller #(
        .N_CH        (NC),
        .BASE_ADDR   (8'hD0),
        .DEB_BITS    (DB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (raw_in),
        .bus_data (bus_data),
        .bus      (bus),
        .level    (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    typedef struct {
        bit [NC-1:0] level;
        bit [NC-1:0] raise;
        bit          oe;
        bit [7:0]    rdata;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    bit [NC-1:0] m_stable, m_pend, m_mask, m_edge, m_both, m_raise;
    bit [NC-1:0] hist[$];

    always @(posedge clk) begin : model
        exp_t        e;
        bit [NC-1:0] set, clr, nxt;
        bit [7:0]    rd;
        bit          hit, agree;
        int          off;
        e = '{default: 0};
        if (!rst_n) begin
            m_stable = '0; m_pend = '0; m_mask = '0;
            m_edge = '0; m_both = '0; m_raise = '0;
            hist.delete();
            repeat (LAT) hist.push_back('0);
        end else begin
            off = int'(bus.addr) - 'hD0;
            hit = (off >= 0) && (off < 5);
            rd  = 8'h00;
            if (hit && !bus.we) begin
                case (off)
                    0: rd = 8'(m_stable);
                    1: rd = 8'(m_pend);
                    2: rd = 8'(m_mask);
                    3: rd = 8'(m_edge);
                    default: rd = 8'(m_both);
                endcase
            end
            hist.push_back(raw_in);
            if (hist.size() > 64) void'(hist.pop_front());
            // The level flips once the raw value seen SS..SS+DEB-1 edges
            // ago has been the opposite of the level throughout.
            nxt = m_stable;
            set = '0;
            for (int ch = 0; ch < NC; ch++) begin
                agree = 1'b1;
                for (int j = hist.size() - LAT; j <= hist.size() - 3; j++)
                    if (hist[j][ch] == m_stable[ch]) agree = 1'b0;
                if (agree) begin
                    nxt[ch] = ~m_stable[ch];
                    if (m_both[ch] || (m_edge[ch] ? !nxt[ch] : nxt[ch])) set[ch] = 1'b1;
                end
            end
            clr = bus.irq_ack;
            if (hit && bus.we && off == 1) clr |= drv_data[NC-1:0];
            m_raise = m_pend & m_mask;
            m_pend  = (m_pend & ~clr) | set;
            if (hit && bus.we) begin
                if (off == 2) m_mask = drv_data[NC-1:0];
                if (off == 3) m_edge = drv_data[NC-1:0];
                if (off == 4) m_both = drv_data[NC-1:0];
            end
            m_stable = nxt;
            e.oe    = hit && !bus.we;
            e.rdata = rd;
        end
        e.level = m_stable;
        e.raise = m_raise;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("level", 8'(level), 8'(e.level));
            chk("irq_raise", 8'(bus.irq_raise), 8'(e.raise));
            if (e.oe)
                chk("read_data", bus_data, e.rdata);
            else if (!drv_oe)
                chk("bus_hiz", bus_data, 8'hFF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr = a; bus.we = 1'b1; drv_data = d; drv_oe = 1'b1;
        tick();
        bus.we = 1'b0; drv_oe = 1'b0; bus.addr = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a);
        bus.addr = a; bus.we = 1'b0;
        tick();
        bus.addr = 8'h00;
        tick();
    endtask

    initial begin : stim
        bit last_rd;
        int op;
        logic [7:0] a;
        bus.addr = 8'h00; bus.we = 1'b0; bus.irq_ack = '0;
        #2;
        chk("reset_level", 8'(level), 8'h00);
        chk("reset_raise", 8'(bus.irq_raise), 8'h00);
        chk("reset_hiz", bus_data, 8'hFF);
        hold(3);
        @(negedge clk); #1 rst_n = 1'b1;
        tick();

        // Readback after reset, masked width, ignored writes/addresses.
        for (int i = 0; i < 5; i++) rd(8'hD0 + 8'(i));
        rd(8'hCF); rd(8'hD5);
        wr(8'hD2, 8'hFF); rd(8'hD2);
        wr(8'hD0, 8'hFF); wr(8'hD5, 8'hFF); rd(8'hD0);
        wr(8'hD2, 8'h00);

        // Glitch shorter than the debounce period is ignored.
        raw_in[0] = 1'b1; hold(10); raw_in[0] = 1'b0; hold(25);
        rd(8'hD1);
        // Held input: level exactly LAT edges after the change.
        raw_in[0] = 1'b1;
        hold(LAT - 1);
        chk("latency_early", 8'(level[0]), 8'h00);
        tick();
        chk("latency_exact", 8'(level[0]), 8'h01);
        rd(8'hD1); wr(8'hD1, 8'h01); rd(8'hD1);

        // Falling-edge channel.
        wr(8'hD3, 8'h02);
        raw_in[1] = 1'b1; hold(25); rd(8'hD1);
        raw_in[1] = 1'b0; hold(25); rd(8'hD1);
        wr(8'hD1, 8'h0F);
        // Both-edge channel with a clear in between.
        wr(8'hD4, 8'h04);
        raw_in[2] = 1'b1; hold(25); rd(8'hD1);
        wr(8'hD1, 8'h04); rd(8'hD1);
        raw_in[2] = 1'b0; hold(25); rd(8'hD1);
        wr(8'hD1, 8'h0F);

        // Masking and acknowledge.
        raw_in[3] = 1'b1; hold(25); rd(8'hD1);
        wr(8'hD2, 8'h08); hold(2);
        chk("unmask_raise", 8'(bus.irq_raise), 8'h08);
        bus.irq_ack = 4'h8; tick(); bus.irq_ack = '0;
        hold(3); rd(8'hD1);

        // Set beats simultaneous ack and W1C on the event edge.
        raw_in[0] = 1'b0; hold(25); wr(8'hD1, 8'h0F);
        raw_in[0] = 1'b1;
        hold(LAT - 1);
        bus.irq_ack = 4'h1; bus.addr = 8'hD1; bus.we = 1'b1; drv_data = 8'h01; drv_oe = 1'b1;
        tick();
        bus.irq_ack = '0; bus.we = 1'b0; drv_oe = 1'b0; bus.addr = 8'h00;
        rd(8'hD1);

        // Reset part way through a debounce period.
        raw_in[0] = 1'b0; hold(25);
        raw_in[0] = 1'b1; hold(8);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_level", 8'(level), 8'h00);
        chk("midrst_raise", 8'(bus.irq_raise), 8'h00);
        hold(2);
        @(negedge clk); #1 rst_n = 1'b1;
        hold(LAT - 1);
        chk("rst_latency_early", 8'(level[0]), 8'h00);
        tick();
        chk("rst_latency_exact", 8'(level[0]), 8'h01);
        rd(8'hD2);

        // Random traffic.
        last_rd = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NC; ch++)
                if ($urandom_range(0, 15) == 0) raw_in[ch] = ~raw_in[ch];
            bus.irq_ack = ($urandom_range(0, 9) == 0) ? NC'($urandom) : '0;
            bus.we = 1'b0; drv_oe = 1'b0; bus.addr = 8'h00;
            op = 2;
            if (!last_rd) begin
                op = $urandom_range(0, 5);
                a  = 8'hCE + 8'($urandom_range(0, 8));
                if (op == 0) begin
                    bus.addr = a; bus.we = 1'b1; drv_data = 8'($urandom); drv_oe = 1'b1;
                end else if (op == 1) begin
                    bus.addr = a;
                end
            end
            last_rd = (op == 1);
            tick();
        end
        bus.irq_ack = '0; bus.we = 1'b0; drv_oe = 1'b0; bus.addr = 8'h00;
        hold(3);
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt source controller for the 8-bit memory-mapped bus.
- Replaces direct wiring of raw buttons onto the processor interrupt lines.
- Each channel has a synchroniser, a debouncer, selectable edge detection, a pending latch and a mask; all are bus-visible.
- Drives the processor's BUS_INTERRUPTS_RAISE lines and clears pending on the processor's per-line acknowledge.

Parameters:
- N_CH, 4, number of interrupt channels (1..8); channel i maps to bus bit i.
- BASE_ADDR, 8'hD0, first bus address of the 5-register window.
- DEB_BITS, 20, debounce counter width; an input must be stable for 2^DEB_BITS cycles before it is accepted.
- SYNC_STAGES, 2, synchroniser flops per raw input (minimum 2).

Ports:
- CLK  in  1  bus clock; the only clock.
- RESET  in  1  asynchronous, active-low reset.
- RAW_IN  in  N_CH  asynchronous raw sources (buttons, peripheral flags).
- BUS_DATA  inout  8  shared bus data; driven only during a read hit, else high-Z.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- IRQ_ACK  in  N_CH  processor acknowledge, 1-cycle pulse per line.
- IRQ_RAISE  out  N_CH  registered pending AND mask, to the processor.
- LEVEL  out  N_CH  debounced input levels.

Behaviour:
- Reset (RESET=0, asynchronous): sync/stable/counters=0, PENDING=0, MASK=0, EDGE=0, BOTH=0, IRQ_RAISE=0, LEVEL=0, BUS_DATA high-Z.
- Register map (offsets from BASE_ADDR):
  - +0 STATUS: RO, debounced levels.
  - +1 PENDING: read; write-1-to-clear.
  - +2 MASK: RW.
  - +3 EDGE: RW; 0=rising, 1=falling.
  - +4 BOTH: RW; 1=both edges, overrides EDGE.
- Register field rules:
  - Bits >= N_CH read 0 and ignore writes.
  - Writes to +0 are ignored.
  - Addresses outside BASE..BASE+4 are ignored.
- Write timing: takes effect on the CLK edge where BUS_WE=1 and the address hits.
- Read timing:
  - When BUS_WE=0 and the address hits, read data and an output-enable flop are registered.
  - BUS_DATA is driven during the following cycle only (1-cycle read latency, same as RAM).
- Synchroniser: SYNC_STAGES flops per channel; the last stage is sync[i].
- Debouncer (per channel; counter cnt is DEB_BITS wide):
  - If sync==stable: cnt<=0.
  - Else if cnt==all-ones: stable<=sync, cnt<=0, event evaluated.
  - Else: cnt<=cnt+1.
  - A glitch shorter than 2^DEB_BITS cycles never changes stable.
- Latency from a raw change to a stable change: SYNC_STAGES + 2^DEB_BITS cycles.
- Event (per channel), on the edge where stable updates:
  - rising = new 1; falling = new 0.
  - Qualified if BOTH[i], or (EDGE[i]==0 and rising), or (EDGE[i]==1 and falling).
  - A qualified event sets PENDING[i] on that same edge.
  - Pending latches regardless of MASK.
- IRQ_RAISE[i] <= PENDING[i] & MASK[i], one cycle after PENDING or MASK changes.
  - Unmasking an already-pending channel raises it next cycle.
- Pending clear: IRQ_ACK[i]=1, or a write of 1 to PENDING bit i; either clears on the next edge.
- Simultaneous set and clear on the same edge: set wins; the event is never lost.
- Reset mid-debounce: the counter is discarded; a held input must complete a full debounce period again after reset release.
- LEVEL = stable.

Decomposition:
- Package irq_ctrl_pkg:
  - Register offset constants (OFF_STATUS=0, OFF_PENDING=1, OFF_MASK=2, OFF_EDGE=3, OFF_BOTH=4).
  - NUM_REGS=5.
  - Bus width constant 8.
- Sub-module debounce_channel, instanced N_CH times:
  - Synchroniser plus debounce counter.
  - Outputs stable, rise_evt, fall_evt.
- Top level holds the bus decode, registers, pending logic and tri-state.

Test Plan:
Common settings for all scenarios: DEB_BITS=4 (16 cycles), N_CH=4, BASE_ADDR=8'hD0.
- Reset/readback: release RESET, read D0..D4 -> all 8'h00; write D2=8'hFF, read D2 -> 8'h0F; BUS_DATA is Z except the cycle after each read.
- Debounce: 10-cycle pulse on RAW_IN[0] -> LEVEL[0] stays 0, PENDING=0. Hold RAW_IN[0] high -> LEVEL[0]=1 exactly 18 cycles after the change, and PENDING[0]=1 on the same edge.
- Edge modes:
  - EDGE=8'h02 (ch1 falling): ch1 high then low -> pending only after the fall.
  - BOTH=8'h04: ch2 high then low -> pending on each edge.
  - Clear PENDING between edges with a write of 8'h04.
- Masking/ack:
  - Pending ch3 with MASK=0 -> IRQ_RAISE=0.
  - Write MASK=8'h08 -> IRQ_RAISE[3]=1 next cycle.
  - IRQ_ACK[3] pulse -> PENDING[3]=0, then IRQ_RAISE[3]=0 one cycle later.
- Collision: a ch0 event edge coincides with IRQ_ACK[0] and with a W1C write of 8'h01 -> PENDING[0] remains 1.
- Reset mid-operation: assert RESET 8 cycles into debouncing a held high input -> all state 0 immediately; after release LEVEL rises 18 cycles later.
